// File: rtl/input_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_reg_bank_pkg
// Description : Shared constants and helpers for the input register bank.
// Revision    : 1.0
// ============================================================================
package input_reg_bank_pkg;

    localparam int c_CH_MIN     = 1;
    localparam int c_CH_MAX     = 32;
    localparam int c_STAGES_MIN = 1;
    localparam int c_STAGES_MAX = 4;
    localparam int c_RATIO_1    = 1;
    localparam int c_RATIO_2    = 2;
    localparam int c_RATIO_4    = 4;

    localparam string c_GSR_ENABLED  = "ENABLED";
    localparam string c_GSR_DISABLED = "DISABLED";

    // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit ratio_legal(input int r);
        return (r == c_RATIO_1) || (r == c_RATIO_2) || (r == c_RATIO_4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_reg_lane.sv
`default_nettype none
// ============================================================================
// Module      : input_reg_lane
// Description : One channel: capture pipeline, deserialising shift register
//               and parallel output word.
// Revision    : 1.0
// ============================================================================
module input_reg_lane #(
    parameter int STAGES = 1,
    parameter int RATIO  = 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_align,
    input  logic             i_ce,
    input  logic             i_tail_ok,
    input  logic             i_last,
    input  logic             i_d,
    output logic [RATIO-1:0] o_word
);

    logic             w_tail;
    logic [RATIO-1:0] w_word;
    logic [RATIO-1:0] r_word;

    generate
        if (STAGES == 1) begin : g_no_pipe
            assign w_tail = i_d;
        end else begin : g_pipe
            logic [STAGES-2:0] r_pipe;
            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_pipe <= '0;
                end else if (!i_align && i_ce) begin
                    r_pipe[0] <= i_d;
                    for (int k = 1; k < STAGES - 1; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end
            assign w_tail = r_pipe[STAGES-2];
        end
    endgenerate

    // Bits enter at the top and walk down, so the oldest bit ends at the LSB.
    generate
        if (RATIO == 1) begin : g_no_shift
            assign w_word = w_tail;
        end else begin : g_shift
            logic [RATIO-2:0] r_shift;
            always_ff @(posedge clk) begin
                if (i_clr || i_align) begin
                    r_shift <= '0;
                end else if (i_ce && i_tail_ok) begin
                    r_shift[RATIO-2] <= w_tail;
                    for (int k = 0; k < RATIO - 2; k++) begin
                        r_shift[k] <= r_shift[k+1];
                    end
                end
            end
            assign w_word = {w_tail, r_shift};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_word <= '0;
        end else if (!i_align && i_ce && i_tail_ok && i_last) begin
            r_word <= w_word;
        end
    end

    assign o_word = r_word;

endmodule
`default_nettype wire

// File: rtl/input_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : input_reg_bank
// Description : CH-channel input register bank with optional capture
//               pipeline and 1:RATIO deserialisation; shared word framing.
// Revision    : 1.0
// ============================================================================
module input_reg_bank
    import input_reg_bank_pkg::*;
#(
    parameter int    CH     = 4,
    parameter int    STAGES = 1,
    parameter int    RATIO  = 1,
    parameter string GSR    = "ENABLED"
) (
    input  logic                SCLK,
    input  logic                RSTN,
    input  logic                CE,
    input  logic                CD,
    input  logic                ALIGN,
    input  logic [CH-1:0]       D,
    output logic [CH*RATIO-1:0] Q,
    output logic                QVALID
);

    localparam int c_FW = cnt_w(STAGES);
    localparam int c_SW = cnt_w(RATIO);
    localparam logic [c_FW-1:0] c_FILL_LAST = c_FW'(STAGES - 1);
    localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(RATIO - 1);
    localparam bit c_GSR_ON = (GSR == c_GSR_ENABLED);

    generate
        if ((CH < c_CH_MIN) || (CH > c_CH_MAX) ||
            (STAGES < c_STAGES_MIN) || (STAGES > c_STAGES_MAX) ||
            !ratio_legal(RATIO) ||
            !((GSR == c_GSR_ENABLED) || (GSR == c_GSR_DISABLED))) begin : g_bad_params
            $error("input_reg_bank: illegal CH/STAGES/RATIO/GSR parameter value");
        end
    endgenerate

    logic            w_rst;
    logic            w_clr;
    logic            w_tail_ok;
    logic            w_last;
    logic [c_FW-1:0] r_fill;
    logic [c_SW-1:0] r_slot;
    logic            r_qvalid;

    assign w_rst     = c_GSR_ON ? ~RSTN : 1'b0;
    assign w_clr     = w_rst | CD;
    assign w_tail_ok = (r_fill == c_FILL_LAST);
    assign w_last    = (r_slot == c_SLOT_LAST);

    always_ff @(posedge SCLK) begin
        if (w_clr) begin
            r_fill   <= '0;
            r_slot   <= '0;
            r_qvalid <= 1'b0;
        end else if (ALIGN) begin
            r_slot   <= '0;
            r_qvalid <= 1'b0;
        end else if (CE) begin
            if (!w_tail_ok) begin
                r_fill <= r_fill + 1'b1;
            end else begin
                r_slot <= w_last ? '0 : r_slot + 1'b1;
            end
            r_qvalid <= w_tail_ok & w_last;
        end else begin
            r_qvalid <= 1'b0;
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_lane
            input_reg_lane #(
                .STAGES (STAGES),
                .RATIO  (RATIO)
            ) u_lane (
                .clk       (SCLK),
                .i_clr     (w_clr),
                .i_align   (ALIGN),
                .i_ce      (CE),
                .i_tail_ok (w_tail_ok),
                .i_last    (w_last),
                .i_d       (D[c]),
                .o_word    (Q[c*RATIO +: RATIO])
            );
        end
    endgenerate

    assign QVALID = r_qvalid;

endmodule
`default_nettype wire

// File: tb/tb_input_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_reg_bank
// Description : Scoreboard bench over four bank configurations.
// Revision    : 1.0
// ============================================================================
module tb_input_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // a: CH1 S1 R1 | b: CH2 S2 R4 | c: CH2 S3 R2 | d: CH1 S1 R2 GSR off
    logic       rstn_a, ce_a, cd_a, al_a, d_a, q_a, qv_a;
    logic       rstn_b, ce_b, cd_b, al_b, qv_b;
    logic [1:0] d_b;
    logic [7:0] q_b;
    logic       rstn_c, ce_c, cd_c, al_c, qv_c;
    logic [1:0] d_c;
    logic [3:0] q_c;
    logic       rstn_d, ce_d, cd_d, al_d, d_d, qv_d;
    logic [1:0] q_d;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_c[$];
    logic [7:0] exp_d[$];

    input_reg_bank #(.CH(1), .STAGES(1), .RATIO(1), .GSR("ENABLED")) dut_a (
        .SCLK(clk), .RSTN(rstn_a), .CE(ce_a), .CD(cd_a), .ALIGN(al_a),
        .D(d_a), .Q(q_a), .QVALID(qv_a));
    input_reg_bank #(.CH(2), .STAGES(2), .RATIO(4), .GSR("ENABLED")) dut_b (
        .SCLK(clk), .RSTN(rstn_b), .CE(ce_b), .CD(cd_b), .ALIGN(al_b),
        .D(d_b), .Q(q_b), .QVALID(qv_b));
    input_reg_bank #(.CH(2), .STAGES(3), .RATIO(2), .GSR("ENABLED")) dut_c (
        .SCLK(clk), .RSTN(rstn_c), .CE(ce_c), .CD(cd_c), .ALIGN(al_c),
        .D(d_c), .Q(q_c), .QVALID(qv_c));
    input_reg_bank #(.CH(1), .STAGES(1), .RATIO(2), .GSR("DISABLED")) dut_d (
        .SCLK(clk), .RSTN(rstn_d), .CE(ce_d), .CD(cd_d), .ALIGN(al_d),
        .D(d_d), .Q(q_d), .QVALID(qv_d));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitors: every QVALID pulse must match the oldest queued word.
    always @(negedge clk) if (qv_a === 1'b1) begin
        if (exp_a.size() == 0) chk("a_spurious_qvalid", 8'(qv_a), 8'h00);
        else chk("a_word", 8'(q_a), exp_a.pop_front());
    end
    always @(negedge clk) if (qv_b === 1'b1) begin
        if (exp_b.size() == 0) chk("b_spurious_qvalid", 8'(qv_b), 8'h00);
        else chk("b_word", q_b, exp_b.pop_front());
    end
    always @(negedge clk) if (qv_c === 1'b1) begin
        if (exp_c.size() == 0) chk("c_spurious_qvalid", 8'(qv_c), 8'h00);
        else chk("c_word", 8'(q_c), exp_c.pop_front());
    end
    always @(negedge clk) if (qv_d === 1'b1) begin
        if (exp_d.size() == 0) chk("d_spurious_qvalid", 8'(qv_d), 8'h00);
        else chk("d_word", 8'(q_d), exp_d.pop_front());
    end

    initial begin
        {rstn_a, ce_a, cd_a, al_a, d_a} = 5'b0;
        {rstn_b, ce_b, cd_b, al_b} = 4'b0; d_b = 2'b00;
        {rstn_c, ce_c, cd_c, al_c} = 4'b0; d_c = 2'b00;
        {rstn_d, ce_d, al_d, d_d} = 4'b0; cd_d = 1'b1;
        step(); step();
        chk("a_reset_q", 8'(q_a), 8'h00);  chk("a_reset_qv", 8'(qv_a), 8'h00);
        chk("b_reset_q", q_b, 8'h00);      chk("b_reset_qv", 8'(qv_b), 8'h00);
        chk("c_reset_q", 8'(q_c), 8'h00);  chk("c_reset_qv", 8'(qv_c), 8'h00);
        chk("d_clear_q", 8'(q_d), 8'h00);  chk("d_clear_qv", 8'(qv_d), 8'h00);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1; rstn_d = 1'b1; cd_d = 1'b0;

        // a: plain register, one word per CE edge
        ce_a = 1'b1;
        d_a = 1'b1; exp_a.push_back(8'h01); step();
        d_a = 1'b0; exp_a.push_back(8'h00); step();
        d_a = 1'b1; exp_a.push_back(8'h01); step();
        ce_a = 1'b0; d_a = 1'b0; step();
        chk("a_hold_ce_low", 8'(q_a), 8'h01);
        ce_a = 1'b1; al_a = 1'b1; step();
        chk("a_align_blocks_load", 8'(q_a), 8'h01);
        ce_a = 1'b0; al_a = 1'b0; step();

        // b: fill edge then ch0 1,0,1,1 / ch1 0,1,1,0 -> {0110,1101}
        ce_b = 1'b1;
        d_b = 2'b01; step();
        d_b = 2'b10; step();
        d_b = 2'b11; step();
        d_b = 2'b01; exp_b.push_back(8'h6D); step();
        d_b = 2'b00; step(); step(); step(); step();
        // restart framing, collect 2 bits, abort, then word 0,1,1,0
        ce_b = 1'b0; al_b = 1'b1; step();
        al_b = 1'b0; ce_b = 1'b1;
        d_b = 2'b11; step();
        d_b = 2'b00; step();
        ce_b = 1'b0; al_b = 1'b1; step();
        al_b = 1'b0; ce_b = 1'b1;
        d_b = 2'b11; step();
        d_b = 2'b11; step();
        d_b = 2'b00; step();
        d_b = 2'b00; exp_b.push_back(8'h66); step();
        // clear lands on a completion edge
        d_b = 2'b11; step(); step(); step();
        cd_b = 1'b1; step();
        cd_b = 1'b0; ce_b = 1'b0;
        chk("b_cd_on_completion", q_b, 8'h00);
        step();

        // d: CE 1,0,1,0 with RATIO 2
        ce_d = 1'b1; d_d = 1'b1; step();
        ce_d = 1'b0; d_d = 1'b0; step();
        chk("d_no_word_yet", 8'(q_d), 8'h00);
        ce_d = 1'b1; d_d = 1'b1; exp_d.push_back(8'h03); step();
        ce_d = 1'b0; d_d = 1'b0; step();
        chk("d_hold", 8'(q_d), 8'h03);
        // RSTN is ignored with GSR disabled
        rstn_d = 1'b0; ce_d = 1'b1;
        d_d = 1'b0; step();
        d_d = 1'b1; exp_d.push_back(8'h02); step();
        ce_d = 1'b0; rstn_d = 1'b1; step();
        chk("d_gsr_off_q", 8'(q_d), 8'h02);

        // c: fill 2 edges, word 11/11, then reset mid-word
        ce_c = 1'b1; d_c = 2'b11;
        step(); step(); step();
        exp_c.push_back(8'h0F); step();
        step();
        rstn_c = 1'b0; step();
        rstn_c = 1'b1;
        chk("c_reset_mid_word_q", 8'(q_c), 8'h00);
        d_c = 2'b01; step();
        d_c = 2'b10; step();
        d_c = 2'b00; step();
        exp_c.push_back(8'h09); step();
        ce_c = 1'b0; step(); step();

        chk("a_pending", 8'(exp_a.size()), 8'h00);
        chk("b_pending", 8'(exp_b.size()), 8'h00);
        chk("c_pending", 8'(exp_c.size()), 8'h00);
        chk("d_pending", 8'(exp_d.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
